// File: rtl/nibbler_pkg.sv
// Shared types for the Nibbler control path: opcodes, sequencer states and ALU selects.
package nibbler_pkg;

  typedef enum logic [3:0] {
    OP_ADDI = 4'h0, OP_ADDM = 4'h1, OP_NORI = 4'h2, OP_NORM = 4'h3,
    OP_CMPI = 4'h4, OP_CMPM = 4'h5, OP_LIT  = 4'h6, OP_LD   = 4'h7,
    OP_ST   = 4'h8, OP_OUT  = 4'h9, OP_IN   = 4'hA, OP_JMP  = 4'hB,
    OP_JC   = 4'hC, OP_JNC  = 4'hD, OP_JZ   = 4'hE, OP_JNZ  = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    FETCH_ADDR = 2'd1,
    EXEC       = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_NOR  = 2'b01,
    ALU_SUB  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_e;

  // Addressed instructions carry a second ROM byte with the low address bits.
  function automatic logic is_addressed(input opcode_e op);
    case (op)
      OP_ADDM, OP_NORM, OP_CMPM, OP_LD, OP_ST,
      OP_JMP, OP_JC, OP_JNC, OP_JZ, OP_JNZ: is_addressed = 1'b1;
      default:                              is_addressed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_flags.sv
// Carry/zero flag register, loaded from the ALU status only when update is high.
module nibbler_flags (
  input  logic clk,
  input  logic reset,
  input  logic update,
  input  logic carry_in,
  input  logic zero_in,
  output logic carry,
  output logic zero
);

  logic carry_reg;
  logic zero_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_reg <= 1'b0;
      zero_reg  <= 1'b0;
    end else if (update) begin
      carry_reg <= carry_in;
      zero_reg  <= zero_in;
    end
  end

  assign carry = carry_reg;
  assign zero  = zero_reg;

endmodule

// File: rtl/nibbler_control.sv
// Nibbler instruction sequencer: fetches opcode/address bytes, holds IR and flags,
// and decodes the active-low datapath strobes during the execute cycle.
module nibbler_control
  import nibbler_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        romData,
  input  logic              aluCarry,
  input  logic              aluZero,
  output logic              notIncPC,
  output logic              notLoadPC,
  output logic              notLoadA,
  output logic              notWriteRAM,
  output logic              notLoadOut,
  output logic              notOeIn,
  output logic [1:0]        aluOp,
  output logic              srcMem,
  output logic [3:0]        imm,
  output logic [ADDR_W-1:0] addr,
  output logic              carryFlag,
  output logic              zeroFlag
);

  state_e     state_reg;
  state_e     state_next;
  logic [7:0] ir_reg;
  logic [7:0] addr_lo_reg;
  opcode_e    op;
  alu_op_e    alu_op;
  logic       flag_update;

  assign op = opcode_e'(ir_reg[7:4]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= FETCH;
      ir_reg      <= 8'h00;
      addr_lo_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      if (state_reg == FETCH)      ir_reg      <= romData;
      if (state_reg == FETCH_ADDR) addr_lo_reg <= romData;
    end
  end

  // Reset forces every strobe inactive combinationally so a write cut off
  // mid-execute cannot land on the next edge.
  always_comb begin
    state_next  = state_reg;
    notIncPC    = 1'b1;
    notLoadPC   = 1'b1;
    notLoadA    = 1'b1;
    notWriteRAM = 1'b1;
    notLoadOut  = 1'b1;
    notOeIn     = 1'b1;
    alu_op      = ALU_PASS;
    srcMem      = 1'b0;
    flag_update = 1'b0;
    case (state_reg)
      FETCH: begin
        notIncPC   = reset;
        state_next = is_addressed(opcode_e'(romData[7:4])) ? FETCH_ADDR : EXEC;
      end
      FETCH_ADDR: begin
        notIncPC   = reset;
        state_next = EXEC;
      end
      EXEC: begin
        state_next = FETCH;
        if (!reset) begin
          case (op)
            OP_ADDI: begin alu_op = ALU_ADD; notLoadA = 1'b0; flag_update = 1'b1; end
            OP_ADDM: begin alu_op = ALU_ADD; notLoadA = 1'b0; flag_update = 1'b1; srcMem = 1'b1; end
            OP_NORI: begin alu_op = ALU_NOR; notLoadA = 1'b0; flag_update = 1'b1; end
            OP_NORM: begin alu_op = ALU_NOR; notLoadA = 1'b0; flag_update = 1'b1; srcMem = 1'b1; end
            OP_CMPI: begin alu_op = ALU_SUB; flag_update = 1'b1; end
            OP_CMPM: begin alu_op = ALU_SUB; flag_update = 1'b1; srcMem = 1'b1; end
            OP_LIT:  notLoadA = 1'b0;
            OP_LD:   begin notLoadA = 1'b0; srcMem = 1'b1; end
            OP_ST:   notWriteRAM = 1'b0;
            OP_OUT:  notLoadOut = 1'b0;
            OP_IN:   begin notLoadA = 1'b0; notOeIn = 1'b0; end
            OP_JMP:  notLoadPC = 1'b0;
            OP_JC:   notLoadPC = ~carryFlag;
            OP_JNC:  notLoadPC = carryFlag;
            OP_JZ:   notLoadPC = ~zeroFlag;
            OP_JNZ:  notLoadPC = zeroFlag;
            default: notLoadPC = 1'b1;
          endcase
        end
      end
      default: state_next = FETCH;
    endcase
  end

  nibbler_flags u_flags (
    .clk      (clk),
    .reset    (reset),
    .update   (flag_update),
    .carry_in (aluCarry),
    .zero_in  (aluZero),
    .carry    (carryFlag),
    .zero     (zeroFlag)
  );

  assign aluOp = alu_op;
  assign imm   = ir_reg[3:0];
  assign addr  = ADDR_W'({ir_reg[3:0], addr_lo_reg});

endmodule
